alu_req_sequencer: RTL and testbench
====================================

// Module: alu_req_sequencer
// PURPOSE
//  Shares one 32-bit ALU instance (AND/OR/XOR/ADD, then left shift 0..15) between two requesters.
//  Round-robin arbitration; one operation in flight at a time.
//  Extends the shift range to 0..31 by running a second ALU pass when needed.
//  Sits between the decode/issue logic and the ALU. The ALU is instantiated by the parent and
//  connected through the alu_* ports.
// PARAMETERS
//  DATA_W   32  operand/result width; must equal ALU width (only 32 supported)
//  SHAMT_W  5   requested shift-amount width (0..31)
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        reset, asynchronous, active-low
//  req_valid    in   2        per requester: operation request valid ([0]=req0, [1]=req1)
//  req_ready    out  2        per requester: request accepted this cycle
//  req0_a       in   DATA_W   requester 0 operand A
//  req0_b       in   DATA_W   requester 0 operand B
//  req0_op      in   2        requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 ADD
//  req0_shamt   in   SHAMT_W  requester 0 left-shift amount applied to op result
//  req1_a/_b/_op/_shamt  in   as above   requester 1 operands
//  rsp_valid    out  2        per requester: result valid
//  rsp_ready    in   2        per requester: result consumed
//  rsp_data     out  DATA_W   result, shared; qualified by rsp_valid
//  alu_a        out  DATA_W   ALU operand A
//  alu_b        out  DATA_W   ALU operand B
//  alu_op       out  2        ALU opcode
//  alu_shift    out  4        ALU shift amount
//  alu_out      in   DATA_W   ALU combinational result
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=0, rsp_valid=0, rsp_data=0; alu_* all 0; last_grant=1
//    (req0 wins the first tie).
//  - States: IDLE, PASS1, PASS2, RESP. Unreachable encodings go to IDLE next cycle.
//  - IDLE: grant = the only valid requester; if both are valid, grant = !last_grant.
//    - req_ready[grant]=1 combinationally in IDLE only. On valid&ready, capture a, b, op, shamt
//      and the grant ID, then go to PASS1.
//    - Nothing valid -> stay in IDLE.
//  - PASS1: alu_a=a, alu_b=b, alu_op=op, alu_shift = (shamt<16) ? shamt[3:0] : 4'd15.
//    Register alu_out into res.
//    - shamt<16 -> RESP; else -> PASS2.
//  - PASS2: alu_a=alu_b=res, alu_op=11 (ADD = x2), alu_shift=shamt-16.
//    - Net shift = 15+1+(shamt-16) = shamt.
//    - Register alu_out into res -> RESP.
//  - Arithmetic: all mod 2^32; the ADD carry-out is discarded; bits shifted past bit 31 are lost.
//  - RESP: rsp_data=res; rsp_valid[grant]=1 held with rsp_data stable until rsp_ready[grant]=1.
//    - On that handshake: last_grant<=grant, rsp_valid->0, go to IDLE.
//    - rsp_ready of the non-granted requester is ignored.
//  - alu_* outputs are 0 in IDLE and RESP. rsp_data holds its last value outside RESP.
//  - Latency: request accepted at edge T -> rsp_valid at T+2 (shamt<16) or T+3 (shamt>=16).
//    Minimum back-to-back period is 3 cycles (4 with PASS2), because a new accept happens only
//    in IDLE.
//  - The other requester's request waits with req_ready=0 while an operation is in flight.
//    Requesters must hold valid and operands until ready.
//  - Fairness: with both requesters continuously valid, grants strictly alternate.
//  - Reset mid-operation: the in-flight operation is dropped, no response is delivered, and all
//    outputs go to their reset values immediately.
// TESTING
//  1. Reset, req0: a=0x0000_00F0, b=0x0000_0F0F, op=00, shamt=0 -> req_ready[0] in IDLE,
//     rsp_valid[0] 2 cycles later, rsp_data=0x0000_0000.
//  2. req1: a=0x1234_5678, b=1, op=11, shamt=4 -> rsp_valid[1], rsp_data=0x2345_6790.
//  3. req0: a=1, b=0, op=01, shamt=31 -> PASS2 taken, rsp after 3 cycles, rsp_data=0x8000_0000;
//     shamt=16 -> 0x0001_0000.
//  4. Both valid continuously for 4 ops -> grants 0,1,0,1; rsp_ready held low 5 cycles ->
//     rsp_valid and rsp_data stable, no new req_ready.
//  5. Assert rst_n low during PASS2 -> rsp_valid never asserts, alu_* = 0, next grant goes to req0.
//  6. req0: a=0xFFFF_FFFF, b=1, op=11, shamt=0 -> rsp_data=0x0000_0000 (carry dropped).

Source files
------------

// File: rtl/alu_req_sequencer.sv
// Purpose: round-robin shares one external 32-bit ALU (op then shl 0..15) between two requesters, shifts 16..31 via a second doubling pass.
// Latency: accept at edge T -> rsp_valid sampled at T+2 (shamt<16) or T+3 (shamt>=16); one operation in flight.
// Backpressure: req_ready only in IDLE; rsp_valid/rsp_data held until the granted requester's rsp_ready.
module alu_req_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic [1:0]         req0_op,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    input  logic [1:0]         req1_op,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [1:0]         alu_op,
    output logic [3:0]         alu_shift,
    input  logic [DATA_W-1:0]  alu_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b11;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [SHAMT_W-1:0]  shamt_q, shamt_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic                sel;
    logic                long_shift;

    // Requester pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        sel = 1'b0;
        if (req_valid == 2'b11) begin
            sel = ~last_grant_q;
        end else begin
            sel = req_valid[1];
        end
    end

    // Shifts beyond the ALU's 0..15 range need the second pass.
    assign long_shift = (shamt_q >= SHAMT_W'(16));

    assign rsp_data = rsp_data_q;

    // State and datapath registers; last_grant resets to 1 so req0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            shamt_q      <= '0;
            res_q        <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            shamt_q      <= shamt_d;
            res_q        <= res_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Next-state, handshake and ALU-drive logic; ALU inputs are zero outside the two passes.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        shamt_d      = shamt_q;
        res_d        = res_q;
        rsp_data_d   = rsp_data_q;
        req_ready    = '0;
        rsp_valid    = '0;
        alu_a        = '0;
        alu_b        = '0;
        alu_op       = '0;
        alu_shift    = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    // Ready is only raised toward a valid requester, so this is the accept.
                    req_ready[sel] = 1'b1;
                    grant_d        = sel;
                    a_d            = sel ? req1_a     : req0_a;
                    b_d            = sel ? req1_b     : req0_b;
                    op_d           = sel ? req1_op    : req0_op;
                    shamt_d        = sel ? req1_shamt : req0_shamt;
                    state_d        = ST_PASS1;
                end
            end

            ST_PASS1: begin
                alu_a     = a_q;
                alu_b     = b_q;
                alu_op    = op_q;
                alu_shift = long_shift ? 4'd15 : shamt_q[3:0];
                res_d     = alu_out;
                if (long_shift) begin
                    state_d = ST_PASS2;
                end else begin
                    rsp_data_d = alu_out;
                    state_d    = ST_RESP;
                end
            end

            ST_PASS2: begin
                // res+res is one more left shift; total = 15 + 1 + (shamt-16).
                alu_a      = res_q;
                alu_b      = res_q;
                alu_op     = OP_ADD;
                alu_shift  = 4'(shamt_q - SHAMT_W'(16));
                rsp_data_d = alu_out;
                state_d    = ST_RESP;
            end

            ST_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Purpose: self-checking bench for alu_req_sequencer with a behavioural ALU on the alu_* ports.
// Latency: expects rsp_valid 2 negedges after accept (3 when shamt>=16).
// Backpressure: holds rsp_ready low to check rsp stability and req_ready suppression.
module tb_alu_req_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [1:0]  alu_op;
    logic [3:0]  alu_shift;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [3:0]  cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_req_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_shamt (req0_shamt),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_shamt (req1_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_shift  (alu_shift),
        .alu_out    (alu_out)
    );

    // Parent-side ALU: op then left shift 0..15.
    logic [31:0] alu_raw;
    always_comb begin
        case (alu_op)
            2'b00:   alu_raw = alu_a & alu_b;
            2'b01:   alu_raw = alu_a | alu_b;
            2'b10:   alu_raw = alu_a ^ alu_b;
            default: alu_raw = alu_a + alu_b;
        endcase
    end
    assign alu_out = alu_raw << alu_shift;

    // Reference: full 0..31 shift of the op result, modulo 2^32.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [4:0] sh);
        logic [31:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = a + b;
        endcase
        return r << sh;
    endfunction

    function automatic logic [1:0] oh(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    task automatic set_ops(input logic id, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [4:0] sh);
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_shamt = sh;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_shamt = sh;
        end
    endtask

    // Present one request, push its expected result, return just after the accept edge.
    task automatic do_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [4:0] sh, output bit acc);
        exp_t e;
        set_ops(id, a, b, op, sh);
        req_valid[id] = 1'b1;
        e.id   = id;
        e.data = model(a, b, op, sh);
        e.cyc  = (sh >= 5'd16) ? 4'd3 : 4'd2;
        sb.push_back(e);
        #1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[id]) begin
                @(posedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        req_valid[id] = 1'b0;
        if (!acc) void'(sb.pop_back());
    endtask

    // Count negedges until any rsp_valid, bounded.
    task automatic wait_rsp(input int start, output int cyc, output bit to);
        cyc = start;
        to  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != 2'b00) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic rsp_ack(input logic id);
        rsp_ready[id] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[id] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        set_ops(1'b0, '0, '0, '0, '0);
        set_ops(1'b1, '0, '0, '0, '0);
        #12;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if ({alu_a, alu_b, alu_op, alu_shift} !== 70'h0) begin errors++;
            $display("FAIL reset_alu: got a=%h b=%h op=%b sh=%h want all 0", alu_a, alu_b, alu_op, alu_shift); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic        t_id [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_a  [5] = '{32'h0000_00F0, 32'h1234_5678, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h0000_0001};
        logic [31:0] t_b  [5] = '{32'h0000_0F0F, 32'h0000_0001, 32'h0000_0001, 32'h0FF0_0FF0, 32'h0000_0000};
        logic [1:0]  t_op [5] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01};
        logic [4:0]  t_sh [5] = '{5'd0, 5'd4, 5'd0, 5'd15, 5'd15};
        exp_t e;
        bit   acc, to;
        int   cyc;
        for (int k = 0; k < 5; k++) begin
            do_req(t_id[k], t_a[k], t_b[k], t_op[k], t_sh[k], acc);
            checks++; if (!acc) begin errors++; $display("FAIL basic_accept[%0d]: got no req_ready want accept", k); end
            wait_rsp(0, cyc, to);
            checks++; if (to) begin errors++; $display("FAIL basic_timeout[%0d]: got no rsp_valid want response", k); end
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            checks++; if (rsp_valid !== oh(e.id)) begin errors++; $display("FAIL basic_valid[%0d]: got %b want %b", k, rsp_valid, oh(e.id)); end
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", k, rsp_data, e.data); end
            checks++; if (cyc !== int'(e.cyc)) begin errors++; $display("FAIL basic_latency[%0d]: got %0d want %0d", k, cyc, e.cyc); end
            rsp_ack(e.id);
        end
    endtask

    task automatic test_pass2;
        logic        t_id [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] t_a  [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007};
        logic [31:0] t_b  [3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0005};
        logic [1:0]  t_op [3] = '{2'b01, 2'b01, 2'b00};
        logic [4:0]  t_sh [3] = '{5'd31, 5'd16, 5'd17};
        exp_t e;
        bit   acc, to;
        int   cyc;
        for (int k = 0; k < 3; k++) begin
            do_req(t_id[k], t_a[k], t_b[k], t_op[k], t_sh[k], acc);
            checks++; if (!acc) begin errors++; $display("FAIL p2_accept[%0d]: got no req_ready want accept", k); end
            @(negedge clk);
            checks++; if ({alu_a, alu_b, alu_op, alu_shift} !== {t_a[k], t_b[k], t_op[k], 4'd15}) begin errors++;
                $display("FAIL p2_pass1_alu[%0d]: got a=%h b=%h op=%b sh=%h want sh=f", k, alu_a, alu_b, alu_op, alu_shift); end
            @(negedge clk);
            checks++; if ({alu_a, alu_b, alu_op, alu_shift} !==
                          {model(t_a[k], t_b[k], t_op[k], 5'd15), model(t_a[k], t_b[k], t_op[k], 5'd15), 2'b11, 4'(t_sh[k] - 5'd16)}) begin
                errors++; $display("FAIL p2_pass2_alu[%0d]: got a=%h b=%h op=%b sh=%h", k, alu_a, alu_b, alu_op, alu_shift); end
            wait_rsp(2, cyc, to);
            checks++; if (to) begin errors++; $display("FAIL p2_timeout[%0d]: got no rsp_valid want response", k); end
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            checks++; if (rsp_valid !== oh(e.id)) begin errors++; $display("FAIL p2_valid[%0d]: got %b want %b", k, rsp_valid, oh(e.id)); end
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL p2_data[%0d]: got %h want %h", k, rsp_data, e.data); end
            checks++; if (cyc !== int'(e.cyc)) begin errors++; $display("FAIL p2_latency[%0d]: got %0d want %0d", k, cyc, e.cyc); end
            rsp_ack(e.id);
        end
    endtask

    task automatic test_fairness;
        logic [31:0] f_a  [2][2] = '{'{32'hA5A5_A5A5, 32'h0000_0003}, '{32'h8000_0000, 32'h0000_1111}};
        logic [31:0] f_b  [2][2] = '{'{32'h0F0F_0F0F, 32'h0000_0004}, '{32'h8000_0000, 32'h0000_2222}};
        logic [1:0]  f_op [2][2] = '{'{2'b00, 2'b01}, '{2'b11, 2'b10}};
        logic [4:0]  f_sh [2][2] = '{'{5'd1, 5'd20}, '{5'd0, 5'd8}};
        int   n [2] = '{0, 0};
        exp_t e;
        logic g;
        bit   to;
        int   cyc;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        set_ops(1'b0, f_a[0][0], f_b[0][0], f_op[0][0], f_sh[0][0]);
        set_ops(1'b1, f_a[1][0], f_b[1][0], f_op[1][0], f_sh[1][0]);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            for (int i = 0; i < 20; i++) begin
                if (req_ready != 2'b00) break;
                @(negedge clk);
            end
            checks++; if (req_ready !== oh(k[0])) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, oh(k[0])); end
            g      = req_ready[1];
            e.id   = g;
            e.data = model(f_a[g][n[g]], f_b[g][n[g]], f_op[g][n[g]], f_sh[g][n[g]]);
            e.cyc  = (f_sh[g][n[g]] >= 5'd16) ? 4'd3 : 4'd2;
            sb.push_back(e);
            @(posedge clk);
            #1;
            n[g]++;
            if (k == 3) req_valid = 2'b00;
            else if (n[g] < 2) set_ops(g, f_a[g][n[g]], f_b[g][n[g]], f_op[g][n[g]], f_sh[g][n[g]]);
            else req_valid[g] = 1'b0;
            wait_rsp(0, cyc, to);
            checks++; if (to) begin errors++; $display("FAIL fair_timeout[%0d]: got no rsp_valid want response", k); end
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            checks++; if (rsp_valid !== oh(e.id)) begin errors++; $display("FAIL fair_valid[%0d]: got %b want %b", k, rsp_valid, oh(e.id)); end
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL fair_data[%0d]: got %h want %h", k, rsp_data, e.data); end
            checks++; if (cyc !== int'(e.cyc)) begin errors++; $display("FAIL fair_latency[%0d]: got %0d want %0d", k, cyc, e.cyc); end
            if (k == 0) begin
                // Stall the response; the other requester's rsp_ready must not release it.
                rsp_ready[!e.id] = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    checks++; if ({rsp_valid, rsp_data, req_ready} !== {oh(e.id), e.data, 2'b00}) begin errors++;
                        $display("FAIL fair_stall[%0d]: got v=%b d=%h rdy=%b want v=%b d=%h rdy=00",
                                 j, rsp_valid, rsp_data, req_ready, oh(e.id), e.data); end
                end
                rsp_ready = 2'b00;
            end
            rsp_ack(e.id);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bit   acc, to, seen;
        int   cyc;
        // Complete a req0 op so that, without reset, the next tie would go to req1.
        do_req(1'b0, 32'h5, 32'h3, 2'b01, 5'd0, acc);
        wait_rsp(0, cyc, to);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        checks++; if (rsp_data !== e.data || to || !acc) begin errors++; $display("FAIL rm_pre_data: got %h want %h", rsp_data, e.data); end
        rsp_ack(1'b0);
        do_req(1'b0, 32'h1, 32'h0, 2'b01, 5'd20, acc);
        checks++; if (!acc) begin errors++; $display("FAIL rm_accept: got no req_ready want accept"); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (sb.size() != 0) void'(sb.pop_back());
        checks++; if ({alu_a, alu_b, alu_op, alu_shift} !== 70'h0) begin errors++;
            $display("FAIL rm_alu: got a=%h b=%h op=%b sh=%h want all 0", alu_a, alu_b, alu_op, alu_shift); end
        checks++; if ({rsp_valid, req_ready, rsp_data} !== 36'h0) begin errors++;
            $display("FAIL rm_outputs: got v=%b rdy=%b d=%h want 0", rsp_valid, req_ready, rsp_data); end
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 2) rst_n = 1'b1;
            if (rsp_valid != 2'b00) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rm_no_rsp: got rsp_valid after reset want none"); end
        set_ops(1'b0, 32'h1, 32'h1, 2'b00, 5'd0);
        set_ops(1'b1, 32'h2, 32'h2, 2'b00, 5'd0);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_next_grant: got %b want 01", req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pass2();
        test_fairness();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
